// File: rtl/dcache_nb_ctrl_if.sv
// Memory-bus bundle between the data-cache controller and the data memory.
interface dcache_nb_ctrl_if;
  logic [1:0]  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [3:0]  Dmem2proc_tag;
  logic [63:0] Dmem2proc_data;

  // Controller side: issues commands, receives response/tag/data.
  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data
  );

  // Memory side.
  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data
  );
endinterface

// File: rtl/dcache_nb_ctrl.sv
// Non-blocking write-through data-cache controller: command FIFO toward
// memory, tag-indexed MSHRs for outstanding loads, store/load hazard stall,
// single CDB broadcast port and halt drain detection.
module dcache_nb_ctrl #(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned NUM_TAGS    = 15,
  parameter int unsigned IDX_BITS    = 7,
  parameter int unsigned TAG_BITS    = 22,
  parameter int unsigned PR_W        = 7,
  parameter int unsigned AR_W        = 5
) (
  input  logic                clock,
  input  logic                reset,
  // load requests from the LSQ
  input  logic                lsq_rd_req,
  input  logic [63:0]         lsq_addr,
  input  logic [PR_W-1:0]     lsq_pr,
  input  logic [AR_W-1:0]     lsq_ar,
  output logic                lsq_ready,
  // retiring stores from the ROB
  input  logic                rob_st_req,
  input  logic [63:0]         rob_st_addr,
  input  logic [63:0]         rob_st_data,
  output logic                rob_st_ready,
  input  logic                rob_halt,
  // cachemem lookup and write ports
  input  logic                cachemem_valid,
  input  logic [63:0]         cachemem_data,
  output logic [IDX_BITS-1:0] dcache_rd_idx,
  output logic [TAG_BITS-1:0] dcache_rd_tag,
  output logic                dcache_wr_en,
  output logic [IDX_BITS-1:0] dcache_wr_idx,
  output logic [TAG_BITS-1:0] dcache_wr_tag,
  output logic [63:0]         dcache_wr_data,
  // memory bus
  dcache_nb_ctrl_if.master    mem,
  // result broadcast
  output logic                cdb_load_en,
  output logic [PR_W-1:0]     cdb_pr,
  output logic [AR_W-1:0]     cdb_ar,
  output logic [63:0]         cdb_data,
  output logic                halt_done
);

  localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned MTAG_W = 4;
  localparam int unsigned MSHR_N = 1 << MTAG_W;
  localparam int unsigned LINE_W = IDX_BITS + TAG_BITS;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2
  } mem_cmd_e;

  typedef struct packed {
    mem_cmd_e        cmd;
    logic [63:0]     addr;
    logic [63:0]     data;
    logic [PR_W-1:0] pr;
    logic [AR_W-1:0] ar;
  } q_entry_t;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [PR_W-1:0]     pr;
    logic [AR_W-1:0]     ar;
  } mshr_t;

  // Architectural state
  q_entry_t                queue_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  qload_q;
  logic [PTR_W-1:0]        head_q;
  logic [PTR_W-1:0]        tail_q;
  logic [CNT_W-1:0]        count_q;
  mshr_t                   mshr_q [MSHR_N];
  logic [MSHR_N-1:0]       mshr_valid_q;
  logic                    halt_pending_q;

  // Combinational control
  logic [LINE_W-1:0]       lookup_line_c;
  logic [LINE_W-1:0]       st_line_c;
  logic [MTAG_W-1:0]       fill_tag_c;
  logic [MTAG_W-1:0]       resp_c;
  mshr_t                   fill_entry_c;
  q_entry_t                head_entry_c;
  q_entry_t                enq_entry_c;
  logic                    fill_c;
  logic                    full_c;
  logic                    empty_c;
  logic                    st_hazard_c;
  logic                    st_acc_c;
  logic                    ld_acc_c;
  logic                    ld_hit_c;
  logic                    ld_miss_c;
  logic                    enq_c;
  logic                    pop_c;
  logic                    alloc_c;

  assign lookup_line_c = rob_st_req ? rob_st_addr[LINE_W+2:3] : lsq_addr[LINE_W+2:3];
  assign st_line_c     = rob_st_addr[LINE_W+2:3];
  assign dcache_rd_idx = lookup_line_c[IDX_BITS-1:0];
  assign dcache_rd_tag = lookup_line_c[LINE_W-1:IDX_BITS];

  assign fill_tag_c   = mem.Dmem2proc_tag;
  assign resp_c       = mem.Dmem2proc_response;
  assign fill_entry_c = mshr_q[fill_tag_c];
  assign head_entry_c = queue_q[head_q];

  assign fill_c  = (fill_tag_c != '0) && (32'(fill_tag_c) <= NUM_TAGS) &&
                   mshr_valid_q[fill_tag_c];
  assign full_c  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty_c = (count_q == '0);

  // A store must wait while any older load to the same line is still pending.
  always_comb begin
    st_hazard_c = 1'b0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if (qload_q[i] && (queue_q[PTR_W'(i)].addr[LINE_W+2:3] == st_line_c)) begin
        st_hazard_c = 1'b1;
      end
    end
    for (int unsigned t = 0; t < MSHR_N; t++) begin
      if (mshr_valid_q[t] &&
          ({mshr_q[MTAG_W'(t)].tag, mshr_q[MTAG_W'(t)].idx} == st_line_c)) begin
        st_hazard_c = 1'b1;
      end
    end
  end

  assign rob_st_ready = !fill_c && !full_c && !st_hazard_c;
  assign lsq_ready    = !rob_st_req && !fill_c && !full_c;

  assign st_acc_c  = rob_st_req && rob_st_ready;
  assign ld_acc_c  = lsq_rd_req && lsq_ready;
  assign ld_hit_c  = ld_acc_c && cachemem_valid;
  assign ld_miss_c = ld_acc_c && !cachemem_valid;
  assign enq_c     = st_acc_c || ld_miss_c;
  assign pop_c     = !empty_c && (resp_c != '0);
  assign alloc_c   = pop_c && (head_entry_c.cmd == CMD_LOAD) &&
                     (32'(resp_c) <= NUM_TAGS);

  assign halt_done = halt_pending_q && empty_c && (mshr_valid_q == '0);

  // Entry pushed at the tail: a retiring store or a missing load.
  always_comb begin
    enq_entry_c = '0;
    if (st_acc_c) begin
      enq_entry_c.cmd  = CMD_STORE;
      enq_entry_c.addr = rob_st_addr;
      enq_entry_c.data = rob_st_data;
    end else begin
      enq_entry_c.cmd  = CMD_LOAD;
      enq_entry_c.addr = lsq_addr;
      enq_entry_c.pr   = lsq_pr;
      enq_entry_c.ar   = lsq_ar;
    end
  end

  // Cache write and CDB: a fill owns both ports, otherwise store write / load hit.
  always_comb begin
    dcache_wr_en   = 1'b0;
    dcache_wr_idx  = '0;
    dcache_wr_tag  = '0;
    dcache_wr_data = '0;
    cdb_load_en    = 1'b0;
    cdb_pr         = '0;
    cdb_ar         = '0;
    cdb_data       = '0;
    if (fill_c) begin
      dcache_wr_en   = 1'b1;
      dcache_wr_idx  = fill_entry_c.idx;
      dcache_wr_tag  = fill_entry_c.tag;
      dcache_wr_data = mem.Dmem2proc_data;
      cdb_load_en    = 1'b1;
      cdb_pr         = fill_entry_c.pr;
      cdb_ar         = fill_entry_c.ar;
      cdb_data       = mem.Dmem2proc_data;
    end else begin
      if (st_acc_c) begin
        dcache_wr_en   = 1'b1;
        dcache_wr_idx  = lookup_line_c[IDX_BITS-1:0];
        dcache_wr_tag  = lookup_line_c[LINE_W-1:IDX_BITS];
        dcache_wr_data = rob_st_data;
      end
      if (ld_hit_c) begin
        cdb_load_en = 1'b1;
        cdb_pr      = lsq_pr;
        cdb_ar      = lsq_ar;
        cdb_data    = cachemem_data;
      end
    end
  end

  // Head of the queue is presented to memory until it is acknowledged.
  always_comb begin
    mem.proc2Dmem_command = CMD_NONE;
    mem.proc2Dmem_addr    = '0;
    mem.proc2Dmem_data    = '0;
    if (!empty_c) begin
      mem.proc2Dmem_command = head_entry_c.cmd;
      mem.proc2Dmem_addr    = head_entry_c.addr;
      mem.proc2Dmem_data    = head_entry_c.data;
    end
  end

  // Pointers, occupancy, MSHR valids and halt tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      qload_q        <= '0;
      mshr_valid_q   <= '0;
      halt_pending_q <= 1'b0;
    end else begin
      if (pop_c) begin
        head_q          <= head_q + PTR_W'(1);
        qload_q[head_q] <= 1'b0;
      end
      if (enq_c) begin
        tail_q          <= tail_q + PTR_W'(1);
        qload_q[tail_q] <= ld_miss_c;
      end
      if (enq_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_c && !enq_c) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (fill_c) begin
        mshr_valid_q[fill_tag_c] <= 1'b0;
      end
      if (alloc_c) begin
        mshr_valid_q[resp_c] <= 1'b1;
      end
      if (rob_halt) begin
        halt_pending_q <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: valid bits and pointers gate every use.
  always_ff @(posedge clock) begin
    if (enq_c) begin
      queue_q[tail_q] <= enq_entry_c;
    end
    if (alloc_c) begin
      mshr_q[resp_c] <= '{idx: head_entry_c.addr[IDX_BITS+2:3],
                          tag: head_entry_c.addr[LINE_W+2:IDX_BITS+3],
                          pr:  head_entry_c.pr,
                          ar:  head_entry_c.ar};
    end
  end

  // Memory must never reuse a tag that is still outstanding.
  always_ff @(posedge clock) begin
    if (!reset && alloc_c) begin
      assert (!mshr_valid_q[resp_c] || (fill_c && (fill_tag_c == resp_c)))
        else $error("dcache_nb_ctrl: memory tag %0d reused while outstanding", resp_c);
    end
  end

endmodule

// File: tb/tb_dcache_nb_ctrl.sv
// Self-checking bench for dcache_nb_ctrl: directed scenarios followed by a
// randomized phase, all checked against a queue/array reference model.
module tb_dcache_nb_ctrl;

  localparam int unsigned QD = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsq_rd_req;
  logic [63:0] lsq_addr;
  logic [6:0]  lsq_pr;
  logic [4:0]  lsq_ar;
  logic        lsq_ready;
  logic        rob_st_req;
  logic [63:0] rob_st_addr;
  logic [63:0] rob_st_data;
  logic        rob_st_ready;
  logic        rob_halt;
  logic        cachemem_valid;
  logic [63:0] cachemem_data;
  logic [6:0]  dcache_rd_idx;
  logic [21:0] dcache_rd_tag;
  logic        dcache_wr_en;
  logic [6:0]  dcache_wr_idx;
  logic [21:0] dcache_wr_tag;
  logic [63:0] dcache_wr_data;
  logic        cdb_load_en;
  logic [6:0]  cdb_pr;
  logic [4:0]  cdb_ar;
  logic [63:0] cdb_data;
  logic        halt_done;

  dcache_nb_ctrl_if mem_if ();

  dcache_nb_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .lsq_rd_req     (lsq_rd_req),
    .lsq_addr       (lsq_addr),
    .lsq_pr         (lsq_pr),
    .lsq_ar         (lsq_ar),
    .lsq_ready      (lsq_ready),
    .rob_st_req     (rob_st_req),
    .rob_st_addr    (rob_st_addr),
    .rob_st_data    (rob_st_data),
    .rob_st_ready   (rob_st_ready),
    .rob_halt       (rob_halt),
    .cachemem_valid (cachemem_valid),
    .cachemem_data  (cachemem_data),
    .dcache_rd_idx  (dcache_rd_idx),
    .dcache_rd_tag  (dcache_rd_tag),
    .dcache_wr_en   (dcache_wr_en),
    .dcache_wr_idx  (dcache_wr_idx),
    .dcache_wr_tag  (dcache_wr_tag),
    .dcache_wr_data (dcache_wr_data),
    .mem            (mem_if),
    .cdb_load_en    (cdb_load_en),
    .cdb_pr         (cdb_pr),
    .cdb_ar         (cdb_ar),
    .cdb_data       (cdb_data),
    .halt_done      (halt_done)
  );

  always #5 clock = ~clock;

  // Reference model: pending commands in order, outstanding loads by tag.
  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [6:0]  pr;
    logic [4:0]  ar;
  } ent_t;

  ent_t q[$];
  ent_t mm [16];
  bit   mv [16];
  bit   hp;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic bit any_mv();
    for (int t = 1; t < 16; t++) if (mv[t]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] valid_tag();
    int c[$];
    for (int t = 1; t < 16; t++) if (mv[t]) c.push_back(t);
    if (c.size() == 0) return 4'd0;
    return 4'(c[$urandom_range(0, c.size() - 1)]);
  endfunction

  function automatic logic [3:0] free_tag(input logic [3:0] avoid);
    int c[$];
    for (int t = 1; t < 16; t++) if (!mv[t] && 4'(t) != avoid) c.push_back(t);
    if (c.size() == 0) return 4'd0;
    return 4'(c[$urandom_range(0, c.size() - 1)]);
  endfunction

  task automatic idle();
    lsq_rd_req = 1'b0; lsq_addr = '0; lsq_pr = '0; lsq_ar = '0;
    rob_st_req = 1'b0; rob_st_addr = '0; rob_st_data = '0; rob_halt = 1'b0;
    cachemem_valid = 1'b0; cachemem_data = '0;
    mem_if.Dmem2proc_response = '0; mem_if.Dmem2proc_tag = '0; mem_if.Dmem2proc_data = '0;
  endtask

  task automatic load(input logic [63:0] a, input logic [6:0] pr, input logic [4:0] ar,
                      input logic hit, input logic [63:0] d);
    lsq_rd_req = 1'b1; lsq_addr = a; lsq_pr = pr; lsq_ar = ar;
    cachemem_valid = hit; cachemem_data = d;
  endtask

  // One cycle: check outputs against the model, clock, then advance the model.
  task automatic step();
    bit fill, full, empty, haz, st_acc, ld_acc, hit, rst, e_wr;
    logic [3:0]  tg, rs;
    logic [63:0] wa, fa;
    ent_t h;
    #2;
    rst   = reset;
    tg    = mem_if.Dmem2proc_tag;
    rs    = mem_if.Dmem2proc_response;
    hit   = cachemem_valid;
    fill  = (tg != 4'd0) && mv[tg];
    full  = (q.size() == QD);
    empty = (q.size() == 0);
    haz   = 1'b0;
    foreach (q[i]) if (q[i].cmd == 2'd1 && q[i].addr[31:3] == rob_st_addr[31:3]) haz = 1'b1;
    for (int t = 1; t < 16; t++) if (mv[t] && mm[t].addr[31:3] == rob_st_addr[31:3]) haz = 1'b1;
    st_acc = rob_st_req && !fill && !full && !haz;
    ld_acc = lsq_rd_req && !rob_st_req && !fill && !full;
    if (!empty) h = q[0];
    if (!rst) begin
      chk("lsq_ready", 64'(lsq_ready), 64'(!rob_st_req && !fill && !full));
      chk("rob_st_ready", 64'(rob_st_ready), 64'(!fill && !full && !haz));
      wa = rob_st_req ? rob_st_addr : lsq_addr;
      chk("rd_idx", 64'(dcache_rd_idx), 64'(wa[9:3]));
      chk("rd_tag", 64'(dcache_rd_tag), 64'(wa[31:10]));
      e_wr = fill || st_acc;
      chk("wr_en", 64'(dcache_wr_en), 64'(e_wr));
      if (e_wr) begin
        fa = fill ? mm[tg].addr : rob_st_addr;
        chk("wr_idx", 64'(dcache_wr_idx), 64'(fa[9:3]));
        chk("wr_tag", 64'(dcache_wr_tag), 64'(fa[31:10]));
        chk("wr_data", dcache_wr_data, fill ? mem_if.Dmem2proc_data : rob_st_data);
      end
      chk("cdb_en", 64'(cdb_load_en), 64'(fill || (ld_acc && hit)));
      if (fill) begin
        chk("cdb_pr_fill", 64'(cdb_pr), 64'(mm[tg].pr));
        chk("cdb_ar_fill", 64'(cdb_ar), 64'(mm[tg].ar));
        chk("cdb_data_fill", cdb_data, mem_if.Dmem2proc_data);
      end else if (ld_acc && hit) begin
        chk("cdb_pr_hit", 64'(cdb_pr), 64'(lsq_pr));
        chk("cdb_ar_hit", 64'(cdb_ar), 64'(lsq_ar));
        chk("cdb_data_hit", cdb_data, cachemem_data);
      end
      if (empty) begin
        chk("mem_cmd_idle", 64'(mem_if.proc2Dmem_command), 64'd0);
        chk("mem_addr_idle", mem_if.proc2Dmem_addr, 64'd0);
        chk("mem_data_idle", mem_if.proc2Dmem_data, 64'd0);
      end else begin
        chk("mem_cmd", 64'(mem_if.proc2Dmem_command), 64'(h.cmd));
        chk("mem_addr", mem_if.proc2Dmem_addr, h.addr);
        if (h.cmd == 2'd2) chk("mem_data", mem_if.proc2Dmem_data, h.data);
      end
      chk("halt_done", 64'(halt_done), 64'(hp && empty && !any_mv()));
    end
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      for (int t = 0; t < 16; t++) mv[t] = 1'b0;
      hp = 1'b0;
    end else begin
      if (fill) mv[tg] = 1'b0;
      if (!empty && rs != 4'd0) begin
        h = q.pop_front();
        if (h.cmd == 2'd1) begin
          mv[rs] = 1'b1;
          mm[rs] = h;
        end
      end
      if (st_acc) q.push_back('{2'd2, rob_st_addr, rob_st_data, 7'd0, 5'd0});
      if (ld_acc && !hit) q.push_back('{2'd1, lsq_addr, 64'd0, lsq_pr, lsq_ar});
      if (rob_halt) hp = 1'b1;
    end
  endtask

  // Retire every queued command and outstanding load, with a cycle bound.
  task automatic drain_all();
    logic [3:0] tg;
    for (int k = 0; k < 400; k++) begin
      if (q.size() == 0 && !any_mv()) break;
      idle();
      tg = valid_tag();
      mem_if.Dmem2proc_tag  = tg;
      mem_if.Dmem2proc_data = {32'($urandom), 32'($urandom)};
      if (q.size() > 0) mem_if.Dmem2proc_response = (q[0].cmd == 2'd1) ? free_tag(tg) : 4'd1;
      step();
    end
    idle();
    #2;
    chk("drain_mem_idle", 64'(mem_if.proc2Dmem_command), 64'd0);
    chk("drain_halt_view", 64'(halt_done), 64'(hp));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lt;
    hp = 1'b0;
    for (int t = 0; t < 16; t++) mv[t] = 1'b0;

    // Reset, then idle outputs
    idle(); reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    // Load hit at 0x100
    load(64'h100, 7'd9, 5'd4, 1'b1, 64'hAA);
    step();
    idle(); step();

    // Load miss at 0x208, tag 3, fill five cycles later
    load(64'h208, 7'd12, 5'd7, 1'b0, 64'h0);
    step();
    idle(); mem_if.Dmem2proc_response = 4'd3;
    step();
    idle();
    repeat (4) step();
    mem_if.Dmem2proc_tag = 4'd3; mem_if.Dmem2proc_data = 64'h55;
    step();
    idle(); step();

    // Fill collides with a hit load
    load(64'h400, 7'd20, 5'd1, 1'b0, 64'h0);
    step();
    idle(); mem_if.Dmem2proc_response = 4'd2;
    step();
    idle(); load(64'h500, 7'd21, 5'd2, 1'b1, 64'h99);
    mem_if.Dmem2proc_tag = 4'd2; mem_if.Dmem2proc_data = 64'h77;
    step();
    mem_if.Dmem2proc_tag = 4'd0;
    step();
    idle(); step();

    // Fill the queue with misses while memory stalls, then check backpressure
    for (int i = 0; i < QD; i++) begin
      idle();
      load(64'h1000 + 64'(i) * 8, 7'(i), 5'(i), 1'b0, 64'h0);
      step();
    end
    idle();
    load(64'h3000, 7'd1, 5'd1, 1'b0, 64'h0);
    rob_st_req = 1'b1; rob_st_addr = 64'h3100; rob_st_data = 64'h1234;
    step();
    // Keep enqueueing while draining so the pointers wrap several times
    for (int i = 0; i < 60; i++) begin
      idle();
      if ($urandom_range(0, 1) == 1) load(64'h5000 + 64'(i) * 8, 7'(i), 5'(i), 1'b0, 64'h0);
      lt = valid_tag();
      mem_if.Dmem2proc_tag  = lt;
      mem_if.Dmem2proc_data = 64'(i);
      if (q.size() > 0) mem_if.Dmem2proc_response = free_tag(lt);
      step();
    end
    drain_all();

    // Store held off by a pending load to the same line
    idle(); load(64'h300, 7'd3, 5'd3, 1'b0, 64'h0);
    step();
    idle(); rob_st_req = 1'b1; rob_st_addr = 64'h300; rob_st_data = 64'hDEAD_BEEF;
    step();
    mem_if.Dmem2proc_response = 4'd4;
    step();
    mem_if.Dmem2proc_response = 4'd0;
    repeat (3) step();
    mem_if.Dmem2proc_tag = 4'd4; mem_if.Dmem2proc_data = 64'h3333;
    step();
    mem_if.Dmem2proc_tag = 4'd0;
    step();
    idle(); mem_if.Dmem2proc_response = 4'd1;
    step();
    idle(); step();

    // Halt with two outstanding loads
    load(64'h600, 7'd30, 5'd10, 1'b0, 64'h0);
    step();
    load(64'h608, 7'd31, 5'd11, 1'b0, 64'h0);
    mem_if.Dmem2proc_response = 4'd5;
    step();
    idle(); mem_if.Dmem2proc_response = 4'd6;
    step();
    idle(); rob_halt = 1'b1;
    step();
    idle(); repeat (3) step();
    mem_if.Dmem2proc_tag = 4'd5; mem_if.Dmem2proc_data = 64'h5;
    step();
    idle(); repeat (2) step();
    mem_if.Dmem2proc_tag = 4'd6; mem_if.Dmem2proc_data = 64'h6;
    step();
    idle(); repeat (2) step();
    reset = 1'b1; step();
    reset = 1'b0; step();

    // Randomized traffic over a small set of lines, with a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      idle();
      if (n == 1500) begin
        lt = valid_tag();
        reset = 1'b1; step();
        reset = 1'b0;
        mem_if.Dmem2proc_tag = lt; mem_if.Dmem2proc_data = 64'hBAD;
        step();
        continue;
      end
      lsq_rd_req     = ($urandom_range(0, 1) == 1);
      lsq_addr       = {32'($urandom), 32'h300 + 32'($urandom_range(0, 63))};
      lsq_pr         = 7'($urandom);
      lsq_ar         = 5'($urandom);
      cachemem_valid = ($urandom_range(0, 2) == 0);
      cachemem_data  = {32'($urandom), 32'($urandom)};
      rob_st_req     = ($urandom_range(0, 3) == 0);
      rob_st_addr    = {32'($urandom), 32'h300 + 32'($urandom_range(0, 63))};
      rob_st_data    = {32'($urandom), 32'($urandom)};
      rob_halt       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) lt = valid_tag();
      else if ($urandom_range(0, 9) == 0) lt = 4'($urandom_range(0, 15));
      else lt = 4'd0;
      mem_if.Dmem2proc_tag  = lt;
      mem_if.Dmem2proc_data = {32'($urandom), 32'($urandom)};
      if (q.size() == 0) mem_if.Dmem2proc_response = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 2) != 0)
        mem_if.Dmem2proc_response = (q[0].cmd == 2'd1) ? free_tag(lt) : 4'($urandom_range(1, 15));
      step();
    end
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
